// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/exception controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    // Default pipeline depth and the role of each stall_o bit in that pipeline.
    localparam int NSTAGE_DEFAULT = 6;
    localparam int STG_PC = 0;
    localparam int STG_IF = 1;
    localparam int STG_ID = 2;
    localparam int STG_EX = 3;
    localparam int STG_LS = 4;
    localparam int STG_WB = 5;

    // The drain watchdog is 8 bits wide, so DRAIN_MAX must be 1..255.
    localparam int WD_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        FLUSH    = 2'd2,
        REDIRECT = 2'd3
    } state_t;

endpackage

// File: rtl/pipe_ctrl_stall_merge.sv
// Combinational stall merge. base: suffix-OR of stall requests, so a stall
// in stage i also holds every younger stage. mask: stages 0..eidx set.
// older_busy: some stage older than eidx still requests a stall.
// Latency: 0 cycles. Backpressure: none.
module stall_merge #(
    parameter int NSTAGE = 6,
    parameter int SIDX_W = $clog2(NSTAGE)
) (
    input  logic [NSTAGE-1:0] stallreq,
    input  logic [SIDX_W-1:0] eidx,
    output logic [NSTAGE-1:0] base,
    output logic [NSTAGE-1:0] mask,
    output logic              older_busy
);

    always_comb begin
        logic acc;
        acc  = 1'b0;
        base = '0;
        mask = '0;
        // Walk from writeback towards pc, accumulating requests.
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            acc     = acc | stallreq[i];
            base[i] = acc;
            mask[i] = (SIDX_W'(i) <= eidx);
        end
        older_busy = |(stallreq & ~mask);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: merges stage stall requests and
// sequences exception entry IDLE -> DRAIN -> FLUSH -> REDIRECT -> IDLE.
// Latency: stall/flush/ack combinational from current state; min 4 cycles per exception.
// Backpressure: REDIRECT holds redirect_valid_o until redirect_ready_i.
// Ports: stallreq_i/stall_o per stage (0=pc), flush_o per pipeline register
// (0=if_id), excp_req_i/excp_stage_i/excp_ack_o from excp, redirect_* to ifu,
// drain_timeout_o watchdog pulse, stall_cycles_o/flush_cnt_o perf counters.
// Optional macro PIPE_CTRL_PERF_EN builds the counters; otherwise they read 0.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE    = NSTAGE_DEFAULT,
    parameter int SIDX_W    = $clog2(NSTAGE),
    parameter int DRAIN_MAX = 255,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NSTAGE-1:0] stallreq_i,
    input  logic              excp_req_i,
    input  logic [SIDX_W-1:0] excp_stage_i,
    output logic              excp_ack_o,
    output logic [NSTAGE-1:0] stall_o,
    output logic [NSTAGE-3:0] flush_o,
    output logic              redirect_valid_o,
    input  logic              redirect_ready_i,
    output logic              drain_timeout_o,
    output logic [CNT_W-1:0]  stall_cycles_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    state_t              state, state_n;
    logic [SIDX_W-1:0]   eidx, eidx_n;
    logic [WD_W-1:0]     wd, wd_n;
    logic [SIDX_W-1:0]   stage_clamped;

    logic [NSTAGE-1:0]   base;
    logic [NSTAGE-1:0]   mask;
    logic                older_busy;

    logic                ack;
    logic                timeout;
    logic                rvld;
    logic [NSTAGE-1:0]   stall;
    logic [NSTAGE-3:0]   flush;

    stall_merge #(
        .NSTAGE (NSTAGE),
        .SIDX_W (SIDX_W)
    ) u_merge (
        .stallreq   (stallreq_i),
        .eidx       (eidx),
        .base       (base),
        .mask       (mask),
        .older_busy (older_busy)
    );

    // Stages 0/1 cannot hold a trapping instruction; unknown indices are
    // treated as the oldest stage so the whole pipe is flushed.
    always_comb begin
        if (excp_stage_i < SIDX_W'(2) || excp_stage_i > SIDX_W'(NSTAGE - 1))
            stage_clamped = SIDX_W'(NSTAGE - 1);
        else
            stage_clamped = excp_stage_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            eidx  <= '0;
            wd    <= '0;
        end else begin
            state <= state_n;
            eidx  <= eidx_n;
            wd    <= wd_n;
        end
    end

    always_comb begin
        state_n = state;
        eidx_n  = eidx;
        wd_n    = wd;
        ack     = 1'b0;
        timeout = 1'b0;
        rvld    = 1'b0;
        stall   = base;
        flush   = '0;
        case (state)
            IDLE: begin
                // Exception beats concurrent stalls; base stall still shown this cycle.
                if (excp_req_i) begin
                    ack     = 1'b1;
                    eidx_n  = stage_clamped;
                    wd_n    = '0;
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                // Freeze the excepting instruction and everything younger
                // while older instructions finish.
                stall = base | mask;
                wd_n  = wd + WD_W'(1);
                if (wd == WD_W'(DRAIN_MAX - 1)) begin
                    timeout = 1'b1;
                    wd_n    = '0;
                    state_n = FLUSH;
                end else if (!older_busy) begin
                    wd_n    = '0;
                    state_n = FLUSH;
                end
            end
            FLUSH: begin
                // Register k feeds stage k+2, so flush k in 0..eidx-2.
                flush   = mask[NSTAGE-1:2];
                stall   = NSTAGE'(1);
                state_n = REDIRECT;
            end
            REDIRECT: begin
                rvld  = 1'b1;
                stall = NSTAGE'(1);
                if (redirect_ready_i)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are forced low for the whole reset, even with requests present.
    assign excp_ack_o       = rst_n & ack;
    assign drain_timeout_o  = rst_n & timeout;
    assign redirect_valid_o = rst_n & rvld;
    assign stall_o          = rst_n ? stall : '0;
    assign flush_o          = rst_n ? flush : '0;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Saturating counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall[0] && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (state == FLUSH && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign stall_cycles_o = stall_cnt;
    assign flush_cnt_o    = flush_cnt;
`else
    assign stall_cycles_o = '0;
    assign flush_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl (NSTAGE=6, DRAIN_MAX=8).
// Each step drives inputs after the rising edge, queues the expected
// outputs, and compares them against the DUT at the falling edge.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst_n;
    logic [5:0]  stallreq;
    logic        excp_req;
    logic [2:0]  excp_stage;
    logic        excp_ack;
    logic [5:0]  stall;
    logic [3:0]  flush;
    logic        redirect_valid;
    logic        redirect_ready;
    logic        drain_timeout;
    logic [31:0] stall_cycles;
    logic [31:0] flush_cnt;

    logic [12:0] obs;
    logic [12:0] sb[$];
    logic [31:0] sbc[$];
    int vectors;
    int miscompares;

    pipe_ctrl #(
        .NSTAGE    (6),
        .DRAIN_MAX (8),
        .CNT_W     (32)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stallreq_i       (stallreq),
        .excp_req_i       (excp_req),
        .excp_stage_i     (excp_stage),
        .excp_ack_o       (excp_ack),
        .stall_o          (stall),
        .flush_o          (flush),
        .redirect_valid_o (redirect_valid),
        .redirect_ready_i (redirect_ready),
        .drain_timeout_o  (drain_timeout),
        .stall_cycles_o   (stall_cycles),
        .flush_cnt_o      (flush_cnt)
    );

    assign obs = {excp_ack, drain_timeout, redirect_valid, stall, flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish before 200000");
        $fatal(1);
    end

    function automatic logic [10:0] S(input logic [5:0] sr, input logic rq,
                                      input logic [2:0] sg, input logic rd);
        return {sr, rq, sg, rd};
    endfunction

    function automatic logic [12:0] E(input logic a, input logic t, input logic r,
                                      input logic [5:0] st, input logic [3:0] fl);
        return {a, t, r, st, fl};
    endfunction

    task automatic apply(input logic [10:0] s, input logic [12:0] e);
        @(posedge clk);
        #1;
        {stallreq, excp_req, excp_stage, redirect_ready} = s;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [12:0] want;
        logic [31:0] wc;
        rst_n = 1'b0;
        {stallreq, excp_req, excp_stage, redirect_ready} = S(6'b111111, 1'b1, 3'd3, 1'b1);
        for (int k = 0; k < 2; k++) begin
            if (k == 0) #3; else @(negedge clk);
            sb.push_back(13'd0);
            sbc.push_back(32'd0);
            sbc.push_back(32'd0);
            want = sb.pop_front();
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL reset_outputs %0d: got %b required %b", k, obs, want);
            end
            wc = sbc.pop_front();
            vectors++;
            if (stall_cycles !== wc) begin
                miscompares++;
                $display("FAIL reset_stall_cycles: got %0d required %0d", stall_cycles, wc);
            end
            wc = sbc.pop_front();
            vectors++;
            if (flush_cnt !== wc) begin
                miscompares++;
                $display("FAIL reset_flush_cnt: got %0d required %0d", flush_cnt, wc);
            end
        end
        {stallreq, excp_req, excp_stage, redirect_ready} = 11'd0;
        rst_n = 1'b1;
    endtask

    task automatic test_base_stall;
        logic [10:0] s [6];
        logic [12:0] e [6];
        logic [12:0] want;
        s[0] = S(6'b000100, 0, 0, 0); e[0] = E(0, 0, 0, 6'b000111, 4'b0000);
        s[1] = S(6'b010000, 0, 0, 0); e[1] = E(0, 0, 0, 6'b011111, 4'b0000);
        s[2] = S(6'b000000, 0, 0, 0); e[2] = E(0, 0, 0, 6'b000000, 4'b0000);
        s[3] = S(6'b100000, 0, 0, 0); e[3] = E(0, 0, 0, 6'b111111, 4'b0000);
        s[4] = S(6'b000001, 0, 0, 1); e[4] = E(0, 0, 0, 6'b000001, 4'b0000);
        s[5] = S(6'b101000, 0, 0, 0); e[5] = E(0, 0, 0, 6'b111111, 4'b0000);
        for (int i = 0; i < 6; i++) begin
            apply(s[i], e[i]);
            want = sb.pop_front();
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL base_stall step %0d: got %b required %b", i, obs, want);
            end
        end
    endtask

    task automatic test_exception;
        logic [10:0] s [5];
        logic [12:0] e [5];
        logic [12:0] want;
        s[0] = S(6'b000000, 1, 3, 0); e[0] = E(1, 0, 0, 6'b000000, 4'b0000);
        s[1] = S(6'b000000, 0, 0, 0); e[1] = E(0, 0, 0, 6'b001111, 4'b0000);
        s[2] = S(6'b000000, 0, 0, 0); e[2] = E(0, 0, 0, 6'b000001, 4'b0011);
        s[3] = S(6'b000000, 0, 0, 1); e[3] = E(0, 0, 1, 6'b000001, 4'b0000);
        s[4] = S(6'b000000, 0, 0, 0); e[4] = E(0, 0, 0, 6'b000000, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            apply(s[i], e[i]);
            want = sb.pop_front();
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL exception step %0d: got %b required %b", i, obs, want);
            end
        end
    endtask

    task automatic test_both_and_clamp;
        logic [10:0] s [10];
        logic [12:0] e [10];
        logic [12:0] want;
        // Stall and exception together, stage 7 clamps to 5.
        s[0] = S(6'b000100, 1, 7, 0); e[0] = E(1, 0, 0, 6'b000111, 4'b0000);
        s[1] = S(6'b000000, 0, 0, 0); e[1] = E(0, 0, 0, 6'b111111, 4'b0000);
        s[2] = S(6'b000000, 0, 0, 0); e[2] = E(0, 0, 0, 6'b000001, 4'b1111);
        s[3] = S(6'b000000, 0, 0, 1); e[3] = E(0, 0, 1, 6'b000001, 4'b0000);
        s[4] = S(6'b000000, 0, 0, 0); e[4] = E(0, 0, 0, 6'b000000, 4'b0000);
        // Stage 1 clamps to 5.
        s[5] = S(6'b000000, 1, 1, 0); e[5] = E(1, 0, 0, 6'b000000, 4'b0000);
        s[6] = S(6'b000000, 0, 0, 0); e[6] = E(0, 0, 0, 6'b111111, 4'b0000);
        s[7] = S(6'b000000, 0, 0, 0); e[7] = E(0, 0, 0, 6'b000001, 4'b1111);
        s[8] = S(6'b000000, 0, 0, 1); e[8] = E(0, 0, 1, 6'b000001, 4'b0000);
        s[9] = S(6'b000000, 0, 0, 0); e[9] = E(0, 0, 0, 6'b000000, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            apply(s[i], e[i]);
            want = sb.pop_front();
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL both_clamp step %0d: got %b required %b", i, obs, want);
            end
        end
    endtask

    task automatic test_drain_hold;
        logic [10:0] s [12];
        logic [12:0] e [12];
        logic [12:0] want;
        // stallreq[4] held 5 cycles; excp_req kept high into DRAIN gets no ack.
        s[0] = S(6'b010000, 1, 2, 0); e[0] = E(1, 0, 0, 6'b011111, 4'b0000);
        for (int i = 1; i < 5; i++) begin
            s[i] = S(6'b010000, 1, 2, 0); e[i] = E(0, 0, 0, 6'b011111, 4'b0000);
        end
        s[5]  = S(6'b000000, 0, 0, 0); e[5]  = E(0, 0, 0, 6'b000111, 4'b0000);
        s[6]  = S(6'b000000, 0, 0, 0); e[6]  = E(0, 0, 0, 6'b000001, 4'b0001);
        for (int i = 7; i < 10; i++) begin
            s[i] = S(6'b000000, 0, 0, 0); e[i] = E(0, 0, 1, 6'b000001, 4'b0000);
        end
        s[10] = S(6'b000000, 0, 0, 1); e[10] = E(0, 0, 1, 6'b000001, 4'b0000);
        s[11] = S(6'b000000, 0, 0, 0); e[11] = E(0, 0, 0, 6'b000000, 4'b0000);
        for (int i = 0; i < 12; i++) begin
            apply(s[i], e[i]);
            want = sb.pop_front();
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL drain_hold step %0d: got %b required %b", i, obs, want);
            end
        end
    endtask

    task automatic test_watchdog;
        logic [10:0] s [12];
        logic [12:0] e [12];
        logic [12:0] want;
        s[0] = S(6'b100000, 1, 3, 0); e[0] = E(1, 0, 0, 6'b111111, 4'b0000);
        for (int i = 1; i < 8; i++) begin
            s[i] = S(6'b100000, 0, 0, 0); e[i] = E(0, 0, 0, 6'b111111, 4'b0000);
        end
        s[8]  = S(6'b100000, 0, 0, 0); e[8]  = E(0, 1, 0, 6'b111111, 4'b0000);
        s[9]  = S(6'b100000, 0, 0, 0); e[9]  = E(0, 0, 0, 6'b000001, 4'b0011);
        s[10] = S(6'b000000, 0, 0, 1); e[10] = E(0, 0, 1, 6'b000001, 4'b0000);
        s[11] = S(6'b000000, 0, 0, 0); e[11] = E(0, 0, 0, 6'b000000, 4'b0000);
        // Second round shows the watchdog restarts from zero.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 12; i++) begin
                apply(s[i], e[i]);
                want = sb.pop_front();
                vectors++;
                if (obs !== want) begin
                    miscompares++;
                    $display("FAIL watchdog round %0d step %0d: got %b required %b", r, i, obs, want);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [10:0] s [4];
        logic [12:0] e [4];
        logic [10:0] p [6];
        logic [12:0] q [6];
        logic [12:0] want;
        s[0] = S(6'b000000, 1, 4, 0); e[0] = E(1, 0, 0, 6'b000000, 4'b0000);
        s[1] = S(6'b000000, 0, 0, 0); e[1] = E(0, 0, 0, 6'b011111, 4'b0000);
        s[2] = S(6'b000000, 0, 0, 0); e[2] = E(0, 0, 0, 6'b000001, 4'b0111);
        s[3] = S(6'b000000, 0, 0, 0); e[3] = E(0, 0, 1, 6'b000001, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            apply(s[i], e[i]);
            want = sb.pop_front();
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL reset_mid setup step %0d: got %b required %b", i, obs, want);
            end
        end
        // Asynchronous reset in the middle of REDIRECT with busy inputs.
        {stallreq, excp_req, excp_stage, redirect_ready} = S(6'b111111, 1, 3, 0);
        #1 rst_n = 1'b0;
        #1;
        sb.push_back(13'd0);
        want = sb.pop_front();
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL reset_mid async: got %b required %b", obs, want);
        end
        @(negedge clk);
        {stallreq, excp_req, excp_stage, redirect_ready} = 11'd0;
        rst_n = 1'b1;
        p[0] = S(6'b000000, 0, 0, 0); q[0] = E(0, 0, 0, 6'b000000, 4'b0000);
        p[1] = S(6'b000000, 1, 3, 1); q[1] = E(1, 0, 0, 6'b000000, 4'b0000);
        p[2] = S(6'b000000, 0, 0, 1); q[2] = E(0, 0, 0, 6'b001111, 4'b0000);
        p[3] = S(6'b000000, 0, 0, 1); q[3] = E(0, 0, 0, 6'b000001, 4'b0011);
        p[4] = S(6'b000000, 0, 0, 1); q[4] = E(0, 0, 1, 6'b000001, 4'b0000);
        p[5] = S(6'b000000, 0, 0, 0); q[5] = E(0, 0, 0, 6'b000000, 4'b0000);
        for (int i = 0; i < 6; i++) begin
            apply(p[i], q[i]);
            want = sb.pop_front();
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL reset_mid after step %0d: got %b required %b", i, obs, want);
            end
        end
    endtask

    task automatic test_perf;
        logic [12:0] want;
        logic [31:0] wc;
        @(negedge clk);
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            apply(S(6'b000001, 0, 0, 0), E(0, 0, 0, 6'b000001, 4'b0000));
            want = sb.pop_front();
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL perf stall step %0d: got %b required %b", i, obs, want);
            end
        end
        apply(S(6'b000000, 1, 3, 1), E(1, 0, 0, 6'b000000, 4'b0000));
        apply(S(6'b000000, 0, 0, 1), E(0, 0, 0, 6'b001111, 4'b0000));
        apply(S(6'b000000, 0, 0, 1), E(0, 0, 0, 6'b000001, 4'b0011));
        apply(S(6'b000000, 0, 0, 1), E(0, 0, 1, 6'b000001, 4'b0000));
        apply(S(6'b000000, 0, 0, 0), E(0, 0, 0, 6'b000000, 4'b0000));
        for (int i = 0; i < 5; i++) begin
            want = sb.pop_front();
            vectors++;
            // Only the final IDLE step is still visible; earlier ones were consumed in order.
            if (i == 4 && obs !== want) begin
                miscompares++;
                $display("FAIL perf exception end: got %b required %b", obs, want);
            end
        end
`ifdef PIPE_CTRL_PERF_EN
        // 10 plain stall cycles + DRAIN + FLUSH + REDIRECT.
        sbc.push_back(32'd13);
        sbc.push_back(32'd1);
`else
        sbc.push_back(32'd0);
        sbc.push_back(32'd0);
`endif
        wc = sbc.pop_front();
        vectors++;
        if (stall_cycles !== wc) begin
            miscompares++;
            $display("FAIL perf stall_cycles: got %0d required %0d", stall_cycles, wc);
        end
        wc = sbc.pop_front();
        vectors++;
        if (flush_cnt !== wc) begin
            miscompares++;
            $display("FAIL perf flush_cnt: got %0d required %0d", flush_cnt, wc);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        {stallreq, excp_req, excp_stage, redirect_ready} = 11'd0;
        test_reset;
        test_base_stall;
        test_exception;
        test_both_and_clamp;
        test_drain_hold;
        test_watchdog;
        test_reset_mid;
        test_perf;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Parametrised pipeline hazard/exception controller for the in-order RISC-V core; successor to the fixed 6-stage combinational stall/flush unit.
- Merges per-stage stall requests into backward-propagating stall vectors for ifu and all pipeline registers.
- Sequences exception entry through drain, flush and redirect states, with a drain watchdog.
- Sits between the stage units, the excp block and ifu.

Parameters:
- NSTAGE, 6, number of stages; stall_o[0]=pc, stall_o[NSTAGE-1]=writeback; NSTAGE-2 pipeline registers.
- SIDX_W, $clog2(NSTAGE), width of a stage index.
- DRAIN_MAX, 255, maximum DRAIN cycles before forced flush; must be ≥1 and fit in 8 bits.
- CNT_W, 32, performance counter width (optional feature only).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- stallreq_i  in  NSTAGE  bit i: stage i requests a stall this cycle.
- excp_req_i  in  1  exception/trap request; held by excp until excp_ack_o.
- excp_stage_i  in  SIDX_W  index of the stage holding the excepting instruction; range 2..NSTAGE-1.
- excp_ack_o  out  1  one-cycle pulse: request accepted.
- stall_o  out  NSTAGE  per-stage stall to ifu and pipeline registers.
- flush_o  out  NSTAGE-2  per-pipeline-register flush; bit k is register k (0=if_id).
- redirect_valid_o  out  1  request ifu to load the trap PC.
- redirect_ready_i  in  1  ifu accepts redirect.
- drain_timeout_o  out  1  one-cycle pulse when the DRAIN watchdog expires.
- stall_cycles_o  out  CNT_W  cycles with stall_o[0]=1 (optional).
- flush_cnt_o  out  CNT_W  completed FLUSH events (optional).

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, eidx=0, watchdog=0, counters=0. While in reset, all outputs are 0.
- Base stall, combinational: base[j] = OR of stallreq_i[i] for all i≥j. Example: NSTAGE=6, stallreq_i=6'b001000 gives base=6'b001111.
- IDLE:
  - stall_o=base, flush_o=0.
  - If excp_req_i=1: latch eidx=excp_stage_i, pulse excp_ack_o in the same cycle, next state DRAIN.
- DRAIN:
  - stall_o = base OR mask(0..eidx); flush_o=0.
  - Exit to FLUSH in the first cycle where stallreq_i bits above eidx are all 0 (older instructions retired or unblocked). Minimum one DRAIN cycle.
  - watchdog increments each DRAIN cycle. When it reaches DRAIN_MAX: pulse drain_timeout_o and go to FLUSH regardless.
  - watchdog clears on leaving DRAIN.
- FLUSH, exactly 1 cycle:
  - flush_o[k]=1 for k in 0..eidx-2, i.e. every register younger than the excepting instruction plus the register holding it.
  - stall_o[0]=1, other stall bits 0.
  - Next state REDIRECT.
- REDIRECT:
  - redirect_valid_o=1, stall_o[0]=1, flush_o=0.
  - Transfer when redirect_valid_o and redirect_ready_i are both 1; next state IDLE.
  - redirect_valid_o stays high until the transfer and must not drop.
- excp_req_i outside IDLE is ignored (no ack); the source keeps holding it.
- Requests with eidx<2 or eidx>NSTAGE-1 are out of range: clamp to NSTAGE-1.
- stallreq_i and excp_req_i both high in IDLE: exception wins and DRAIN begins that cycle. The base stall still applies in that same cycle, because stall_o is combinational from the current state.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined:
  - stall_cycles_o increments each cycle stall_o[0]=1.
  - flush_cnt_o increments on each FLUSH cycle.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports remain and are tied to 0; no counter flops are built.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state encoding IDLE=2'd0, DRAIN=2'd1, FLUSH=2'd2, REDIRECT=2'd3;
  - default NSTAGE and the stage index constants (PC=0, IF=1, ID=2, EX=3, LS=4, WB=5).
- One sub-module, stall_merge: purely combinational suffix-OR (base) plus the eidx mask generator, parametrised by NSTAGE.
- FSM, watchdog and counters stay in pipe_ctrl.

Test Plan:
- NSTAGE=6, IDLE, stallreq_i=6'b000100 -> stall_o=6'b000111, flush_o=0. stallreq_i=6'b010000 -> stall_o=6'b011111.
- excp_req_i=1, excp_stage_i=3, stallreq_i=0 -> excp_ack_o pulse; DRAIN 1 cycle (stall_o=6'b001111); FLUSH flush_o=4'b0011, stall_o=6'b000001; REDIRECT with redirect_ready_i=1 next cycle -> IDLE in 4 cycles total.
- excp_stage_i=2 with stallreq_i[4] held high for 5 cycles -> DRAIN lasts 5 cycles, then flush_o=4'b0001. Hold redirect_ready_i=0 for 3 cycles -> redirect_valid_o stays high 4 cycles.
- DRAIN_MAX=8, stallreq_i[5] stuck high -> drain_timeout_o pulses after 8 DRAIN cycles, FLUSH follows next cycle.
- Reset asserted asynchronously mid-REDIRECT -> redirect_valid_o, stall_o and flush_o go to 0 immediately; state is IDLE after release. A second excp_req_i during DRAIN gets no ack.
- With PIPE_CTRL_PERF_EN: 10 stalled cycles plus one exception -> stall_cycles_o=10+exception stall cycles, flush_cnt_o=1. Without the macro, both read 0.
